// File: rtl/tank_map_pkg.sv
// tank_map_pkg: shared playfield constants, tile/state enums and the default 20x15 tile map
package tank_map_pkg;
  localparam int MAP_W       = 20;
  localparam int MAP_H       = 15;
  localparam int MAP_SIZE    = 300;
  localparam int TILE_BITS   = 3;
  localparam int P1_BASE_IDX = 269;
  localparam int P2_BASE_IDX = 29;
  typedef enum logic [TILE_BITS-1:0] {EMPTY, BORDER, BRICK, BASE1, BASE2} tile_t;
  typedef enum logic {PLAY, OVER} state_t;
  // Layout: border ring, brick walls shielding each base, and a field of brick pillars in the middle.
  function automatic tile_t default_tile(input int idx);
    int row;
    int col;
    row = idx / MAP_W;
    col = idx % MAP_W;
    if (idx == P1_BASE_IDX) return BASE1;
    if (idx == P2_BASE_IDX) return BASE2;
    if (row == 0 || row == MAP_H-1 || col == 0 || col == MAP_W-1) return BORDER;
    if ((row == 2 || row == 12) && col >= 2 && col <= 17) return BRICK;
    if ((row == 1 || row == 13) && (col == 8 || col == 10)) return BRICK;
    if (row >= 5 && row <= 9 && col % 4 == 1) return BRICK;
    return EMPTY;
  endfunction
  function automatic logic [MAP_SIZE*TILE_BITS-1:0] build_map();
    logic [MAP_SIZE*TILE_BITS-1:0] m;
    m = '0;
    for (int i = 0; i < MAP_SIZE; i++) m[i*TILE_BITS +: TILE_BITS] = default_tile(i);
    return m;
  endfunction
  // Packed so it can be a plain constant; tile i lives at [i*TILE_BITS +: TILE_BITS].
  localparam logic [MAP_SIZE*TILE_BITS-1:0] DEFAULT_MAP = build_map();
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; search starts after the last granted index
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : sync clear; suppresses grants and reloads the pointer
//   i_req          : request vector
//   o_gnt, o_idx   : one-hot grant and its index (combinational)
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx
);
  logic [IDX_W-1:0] r_ptr;
  // Walk from farthest to nearest so the nearest requester after r_ptr wins.
  always_comb begin
    o_gnt = '0;
    o_idx = r_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (i_req[(int'(r_ptr) + k) % NUM_REQ]) begin
        o_gnt = '0;
        o_gnt[(int'(r_ptr) + k) % NUM_REQ] = 1'b1;
        o_idx = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
    if (i_clr) o_gnt = '0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_ptr <= IDX_W'(NUM_REQ-1);
    else if (i_clr) r_ptr <= IDX_W'(NUM_REQ-1);
    else if (|o_gnt) r_ptr <= o_idx;
endmodule

// File: rtl/tile_map_arbiter.sv
// tile_map_arbiter: shared playfield tile map with round-robin access, video read port and game-over tracking
//   Clk, Reset_n        : clock, async active-low reset
//   restart             : sync pulse; reload default map, clear flags, drop grants
//   req, we, addr       : per-requester request, destroy flag, packed tile index
//   gnt                 : one-hot grant (combinational)
//   rvalid, rid, rdata  : registered response carrying the pre-access tile
//   vid_addr, vid_tile  : never-stalled registered read for the color mapper
//   base_hit, game_over : sticky base-destroyed flags, OVER state indicator
module tile_map_arbiter
  import tank_map_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 9,
  parameter int TILE_W  = 3
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      restart,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rvalid,
  output logic [1:0]                rid,
  output logic [TILE_W-1:0]         rdata,
  input  logic [ADDR_W-1:0]         vid_addr,
  output logic [TILE_W-1:0]         vid_tile,
  output logic [1:0]                base_hit,
  output logic                      game_over
);
  localparam int IDX_W = $clog2(NUM_REQ);
  logic [TILE_W-1:0] r_map [MAP_SIZE];
  logic [1:0]        r_base_hit;
  logic              r_rvalid;
  logic [1:0]        r_rid;
  logic [TILE_W-1:0] r_rdata;
  logic [TILE_W-1:0] r_vid;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  w_idx;
  logic [ADDR_W-1:0] w_addr;
  logic [TILE_W-1:0] w_old;
  logic              w_any;
  logic              w_in_range;
  logic              w_vid_in_range;
  logic              w_destroy;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_clr   (restart),
    .i_req   (req),
    .o_gnt   (gnt),
    .o_idx   (w_idx)
  );
  assign w_any          = |gnt;
  assign w_addr         = addr[w_idx*ADDR_W +: ADDR_W];
  assign w_in_range     = w_addr < ADDR_W'(MAP_SIZE);
  assign w_vid_in_range = vid_addr < ADDR_W'(MAP_SIZE);
  // Off-map indices read as border so movement logic treats them as walls.
  assign w_old          = w_in_range ? r_map[w_addr] : TILE_W'(BORDER);
  // Only breakable tiles change, and only while play is live.
  assign w_destroy      = w_any && we[w_idx] && w_in_range && r_state == PLAY &&
                          (w_old == TILE_W'(BRICK) || w_old == TILE_W'(BASE1) || w_old == TILE_W'(BASE2));
  always_comb begin
    w_state_nxt = restart ? PLAY : (r_state == PLAY && |r_base_hit) ? OVER : r_state;
    game_over   = r_state == OVER;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) r_state <= PLAY;
    else r_state <= w_state_nxt;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      for (int i = 0; i < MAP_SIZE; i++) r_map[i] <= TILE_W'(DEFAULT_MAP[i*TILE_BITS +: TILE_BITS]);
      r_base_hit <= '0;
    end else if (restart) begin
      for (int i = 0; i < MAP_SIZE; i++) r_map[i] <= TILE_W'(DEFAULT_MAP[i*TILE_BITS +: TILE_BITS]);
      r_base_hit <= '0;
    end else if (w_destroy) begin
      r_map[w_addr] <= TILE_W'(EMPTY);
      r_base_hit    <= r_base_hit | {w_old == TILE_W'(BASE2), w_old == TILE_W'(BASE1)};
    end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      r_rvalid <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
      r_vid    <= '0;
    end else begin
      r_rvalid <= w_any;
      r_rid    <= w_any ? 2'(w_idx) : r_rid;
      r_rdata  <= w_any ? w_old : r_rdata;
      r_vid    <= w_vid_in_range ? r_map[vid_addr] : TILE_W'(BORDER);
    end
  assign rvalid   = r_rvalid;
  assign rid      = r_rid;
  assign rdata    = r_rdata;
  assign vid_tile = r_vid;
  assign base_hit = r_base_hit;
endmodule

// File: tb/tb_tile_map_arbiter.sv
// tb_tile_map_arbiter: directed self-checking bench for tile_map_arbiter
module tb_tile_map_arbiter;
  logic        Clk;
  logic        Reset_n;
  logic        restart;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [35:0] addr;
  logic [3:0]  gnt;
  logic        rvalid;
  logic [1:0]  rid;
  logic [2:0]  rdata;
  logic [8:0]  vid_addr;
  logic [2:0]  vid_tile;
  logic [1:0]  base_hit;
  logic        game_over;
  int          n_chk;
  int          n_fail;
  tile_map_arbiter dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .restart   (restart),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rid       (rid),
    .rdata     (rdata),
    .vid_addr  (vid_addr),
    .vid_tile  (vid_tile),
    .base_hit  (base_hit),
    .game_over (game_over)
  );
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end
  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask
  task automatic access(input int r, input bit w, input int a, input int exp_rdata, input string tag);
    req           = '0;
    we            = '0;
    req[r]        = 1'b1;
    we[r]         = w;
    addr[r*9 +: 9] = 9'(a);
    #1;
    check({tag, " gnt"}, int'(gnt), 1 << r);
    cycle();
    req = '0;
    we  = '0;
    check({tag, " rvalid"}, int'(rvalid), 1);
    check({tag, " rid"}, int'(rid), r);
    check({tag, " rdata"}, int'(rdata), exp_rdata);
  endtask
  initial begin
    n_chk    = 0;
    n_fail   = 0;
    Reset_n  = 1'b0;
    restart  = 1'b0;
    req      = '0;
    we       = '0;
    addr     = '0;
    vid_addr = '0;
    #3;
    check("rst gnt", int'(gnt), 0);
    check("rst rvalid", int'(rvalid), 0);
    check("rst rid", int'(rid), 0);
    check("rst rdata", int'(rdata), 0);
    check("rst vid_tile", int'(vid_tile), 0);
    check("rst base_hit", int'(base_hit), 0);
    check("rst game_over", int'(game_over), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    cycle();
    // Round robin across all four, then alternating pair.
    req = 4'b1111;
    #1;
    check("rr all 0", int'(gnt), 4'b0001);
    cycle();
    check("rr all 1", int'(gnt), 4'b0010);
    check("rr rid 0", int'(rid), 0);
    cycle();
    check("rr all 2", int'(gnt), 4'b0100);
    check("rr rid 1", int'(rid), 1);
    cycle();
    check("rr all 3", int'(gnt), 4'b1000);
    cycle();
    check("rr wrap", int'(gnt), 4'b0001);
    req = 4'b0101;
    #1;
    check("rr pair 0", int'(gnt), 4'b0001);
    cycle();
    check("rr pair 1", int'(gnt), 4'b0100);
    cycle();
    check("rr pair 2", int'(gnt), 4'b0001);
    cycle();
    check("rr pair 3", int'(gnt), 4'b0100);
    cycle();
    req = '0;
    #1;
    check("idle gnt", int'(gnt), 0);
    check("last rid", int'(rid), 2);
    cycle();
    check("rvalid pulse", int'(rvalid), 0);
    // Basic read and video port.
    vid_addr = 9'd0;
    access(0, 1'b0, 28, 2, "read 28");
    check("vid 0", int'(vid_tile), 1);
    // Destroy behaviour.
    access(2, 1'b1, 28, 2, "kill 28");
    access(1, 1'b0, 28, 0, "reread 28");
    access(3, 1'b1, 0, 1, "kill border");
    access(0, 1'b0, 0, 1, "reread border");
    access(2, 1'b1, 310, 1, "kill oob");
    vid_addr = 9'd310;
    cycle();
    check("vid oob", int'(vid_tile), 1);
    check("no hit yet", int'(base_hit), 0);
    // Same-cycle write and video read of one tile.
    vid_addr = 9'd45;
    access(1, 1'b1, 45, 2, "kill 45");
    check("vid old 45", int'(vid_tile), 2);
    cycle();
    check("vid new 45", int'(vid_tile), 0);
    // Base destruction and OVER state.
    access(0, 1'b1, 269, 3, "kill base1");
    check("base_hit set", int'(base_hit), 1);
    check("over not yet", int'(game_over), 0);
    cycle();
    check("game_over", int'(game_over), 1);
    access(2, 1'b1, 48, 2, "over kill 48");
    access(3, 1'b0, 48, 2, "over reread 48");
    access(1, 1'b1, 29, 4, "over kill base2");
    check("base_hit held", int'(base_hit), 1);
    access(0, 1'b0, 29, 4, "over reread 29");
    // Restart beats a request in the same cycle.
    restart = 1'b1;
    req     = 4'b0010;
    #1;
    check("restart gnt", int'(gnt), 0);
    cycle();
    restart = 1'b0;
    req     = '0;
    check("restart rvalid", int'(rvalid), 0);
    check("restart base_hit", int'(base_hit), 0);
    check("restart game_over", int'(game_over), 0);
    access(1, 1'b0, 269, 3, "restored 269");
    access(0, 1'b0, 28, 2, "restored 28");
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    req     = 4'b1111;
    #1;
    check("restart ptr", int'(gnt), 4'b0001);
    cycle();
    req = '0;
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
